// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and the round-robin scan function for rr_select_arbiter.
package rr_arb_pkg;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned IDXW_DEF = $clog2(N_DEF);
  localparam int unsigned MAX_N    = 32;
  localparam int unsigned MAX_IDXW = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Scans req upward from last+1, wrapping at n-1; returns 1 and the winner when any bit is set.
  function automatic logic rr_next_idx(input  logic [MAX_N-1:0] req,
                                       input  int unsigned      last,
                                       input  int unsigned      n,
                                       output int unsigned      idx);
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = last;
    for (int unsigned off = 1; off <= MAX_N; off++) begin
      cand = last + off;
      if (cand >= n) begin
        cand = cand - n;
      end
      if (!found && (off <= n) && req[cand[MAX_IDXW-1:0]]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational binary-index to one-hot decoder; all zero when en is low.
module idx_onehot_dec #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [N-1:0]    onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IDXW'(i));
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin owner arbiter for a one-hot select resource with a break-before-make gap.
// Optional grant length limit enabled by defining HOLD_LIMIT_EN.
module rr_select_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned  N        = N_DEF,
  parameter int unsigned  MAX_HOLD = 16,
  localparam int unsigned IDXW     = (N == N_DEF) ? IDXW_DEF : ((N > 1) ? $clog2(N) : 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  if (N > MAX_N || N < 2) begin : g_bad_n
    $error("rr_select_arbiter: N out of supported range");
  end
  if (MAX_HOLD == 0) begin : g_bad_max_hold
    $error("rr_select_arbiter: MAX_HOLD must be >= 1");
  end

  state_t          state_q, state_d;
  logic [IDXW-1:0] last_ptr_q, last_ptr_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            found;
  int unsigned     pick_idx;

`ifdef HOLD_LIMIT_EN
  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           preempt_q, preempt_d;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    last_ptr_d  = last_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = 1'b0;
    pick_idx    = 0;
`ifdef HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;
`endif
    found = rr_next_idx(MAX_N'(req), 32'(last_ptr_q), N, pick_idx);

    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d     = GRANT;
          gnt_idx_d   = IDXW'(pick_idx);
          last_ptr_d  = IDXW'(pick_idx);
          gnt_valid_d = 1'b1;
`ifdef HOLD_LIMIT_EN
          hold_cnt_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (req[gnt_idx_q]) begin
`ifdef HOLD_LIMIT_EN
          if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
            state_d    = GAP;
            preempt_d  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            gnt_valid_d = 1'b1;
            hold_cnt_d  = hold_cnt_q + HCW'(1);
          end
`else
          gnt_valid_d = 1'b1;
`endif
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  idx_onehot_dec #(
    .N    (N),
    .IDXW (IDXW)
  ) u_dec (
    .idx    (gnt_idx_d),
    .en     (gnt_valid_d),
    .onehot (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_ptr_q  <= IDXW'(N - 1);
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
    end
  end

`ifdef HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: vector table plus fairness and hold-limit sequences.
module tb_rr_select_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       pre;
    string      name;
  } vec_t;

  vec_t tbl[$];

  rr_select_arbiter #(
    .N        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] g,
                              input logic [2:0] i, input logic p, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.idx = i; v.pre = p; v.name = nm;
    return v;
  endfunction

  // Apply inputs, take one rising edge, then compare all outputs 1 time unit later.
  task automatic tick_check(input logic r, input logic [7:0] rq, input logic [7:0] eg,
                            input logic [2:0] ei, input logic ep, input string nm);
    logic ev;
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
    ev = |eg;
    tests_run++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || preempt !== ep) begin
      tests_failed++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b preempt=%b, want gnt=%h idx=%0d valid=%b preempt=%b",
               nm, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
    end
  endtask

  initial begin
    logic [7:0] one;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    req = 8'h00;

    // Reset, single requester, wrap from 7 to 0, non-owner changes ignored, reset mid-grant.
    tbl.push_back(mk(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_0"));
    tbl.push_back(mk(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_1"));
    tbl.push_back(mk(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_2"));
    tbl.push_back(mk(1'b0, 8'h08, 8'h08, 3'd3, 1'b0, "single_grant3"));
    tbl.push_back(mk(1'b0, 8'h08, 8'h08, 3'd3, 1'b0, "single_hold3"));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 3'd3, 1'b0, "single_release_gap"));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 3'd3, 1'b0, "single_idle"));
    tbl.push_back(mk(1'b0, 8'h80, 8'h80, 3'd7, 1'b0, "grant7"));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 3'd7, 1'b0, "release7_gap"));
    tbl.push_back(mk(1'b0, 8'h81, 8'h01, 3'd0, 1'b0, "wrap_to_0"));
    tbl.push_back(mk(1'b0, 8'h81, 8'h01, 3'd0, 1'b0, "hold0_with_7_waiting"));
    tbl.push_back(mk(1'b0, 8'h80, 8'h00, 3'd0, 1'b0, "release0_gap"));
    tbl.push_back(mk(1'b0, 8'h80, 8'h80, 3'd7, 1'b0, "grant7_after_gap"));
    tbl.push_back(mk(1'b0, 8'hC0, 8'h80, 3'd7, 1'b0, "nonowner_ignored"));
    tbl.push_back(mk(1'b0, 8'h40, 8'h00, 3'd7, 1'b0, "release7_gap2"));
    tbl.push_back(mk(1'b0, 8'h40, 8'h40, 3'd6, 1'b0, "grant6"));
    tbl.push_back(mk(1'b0, 8'hFF, 8'h40, 3'd6, 1'b0, "hold6_all_req"));
    tbl.push_back(mk(1'b0, 8'h04, 8'h00, 3'd6, 1'b0, "release6_gap"));
    tbl.push_back(mk(1'b0, 8'h04, 8'h04, 3'd2, 1'b0, "grant2"));
    tbl.push_back(mk(1'b1, 8'h04, 8'h00, 3'd0, 1'b0, "reset_mid_grant"));
    tbl.push_back(mk(1'b0, 8'h44, 8'h04, 3'd2, 1'b0, "ptr_reset_grant2"));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 3'd2, 1'b0, "release2_gap"));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 3'd2, 1'b0, "idle_holds_idx"));

    foreach (tbl[i]) begin
      tick_check(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].idx, tbl[i].pre, tbl[i].name);
    end

    // Fairness: all requesting; each owner holds 2 cycles, drops, then reasserts.
    tick_check(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rr_reset");
    tick_check(1'b0, 8'hFF, 8'h01, 3'd0, 1'b0, "rr_first_grant");
    for (int k = 0; k < 9; k++) begin
      one = 8'h01 << (k % 8);
      tick_check(1'b0, 8'hFF, one, 3'(k % 8), 1'b0, "rr_hold");
      tick_check(1'b0, 8'hFF & ~one, 8'h00, 3'(k % 8), 1'b0, "rr_gap");
      one = 8'h01 << ((k + 1) % 8);
      tick_check(1'b0, 8'hFF, one, 3'((k + 1) % 8), 1'b0, "rr_next_owner");
    end

    // Continuous single request: limited grants with preempt, or one unbroken grant.
    tick_check(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "hold_reset");
`ifdef HOLD_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick_check(1'b0, 8'h20, 8'h20, 3'd5, 1'b0, "limit_grant");
      end
      tick_check(1'b0, 8'h20, 8'h00, 3'd5, 1'b1, "limit_preempt_gap");
    end
    tick_check(1'b0, 8'h20, 8'h20, 3'd5, 1'b0, "limit_regrant");
`else
    for (int c = 0; c < 10; c++) begin
      tick_check(1'b0, 8'h20, 8'h20, 3'd5, 1'b0, "nolimit_hold");
    end
`endif
    tick_check(1'b0, 8'h00, 8'h00, 3'd5, 1'b0, "final_release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
